icache_line_buffer: RTL and testbench

//  Blocking instruction cache of NUM_LINES fully-associative 16-byte lines.

---
 rtl/icache_line_buffer.sv | 168 ++++++++++++++++
 tb/tb_icache_line_buffer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_buffer.sv
// Blocking, fully-associative instruction cache of NUM_LINES 16-byte lines with 4-beat refill.
// Optional hit/miss counters (perf_hit, perf_miss) are built when ICACHE_PERF_CNT_EN is defined.
module icache_line_buffer #(
  parameter int NUM_LINES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid,
  output logic         ready,
  input  logic [31:0]  araddr,
  input  logic         uncached,
  output logic         rvalid,
  output logic [127:0] rdata,
  input  logic         cacop_en,
  input  logic [1:0]   cacop_code,
  input  logic [31:0]  cacop_addr,
  output logic         rd_req,
  output logic [2:0]   rd_type,
  output logic [31:0]  rd_addr,
  input  logic         rd_rdy,
  input  logic         ret_valid,
  input  logic         ret_last,
`ifdef ICACHE_PERF_CNT_EN
  input  logic [31:0]  ret_data,
  output logic [31:0]  perf_hit,
  output logic [31:0]  perf_miss
`else
  input  logic [31:0]  ret_data
`endif
);

  localparam int IW = $clog2(NUM_LINES);

  typedef enum logic [1:0] {IDLE, MISS, REFILL} state_t;

  state_t               state, state_nxt;
  logic [27:0]          tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];
  logic [NUM_LINES-1:0] line_vld;
  logic [IW-1:0]        repl_ptr;
  logic [1:0]           beat_cnt;
  logic [127:0]         fill_buf;
  logic [127:0]         fill_next;
  logic [27:0]          miss_tag;
  logic                 miss_unc;

  logic                 hit;
  logic [IW-1:0]        hit_idx;
  logic                 accept_cop;
  logic                 fetch_hit;
  logic                 fetch_miss;
  logic                 beat_last;
  logic                 line_wr;
  logic                 unused_bits;

  assign unused_bits = ^{araddr[3:0], cacop_addr[3:0]};

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (line_vld[i] && (tag_q[i] == araddr[31:4])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Cacop has priority; a fetch presented alongside it waits for the next cycle.
  assign ready      = (state == IDLE) && !reset;
  assign accept_cop = ready && cacop_en;
  assign fetch_hit  = ready && valid && !cacop_en && !uncached && hit;
  assign fetch_miss = ready && valid && !cacop_en && (uncached || !hit);
  assign beat_last  = (state == REFILL) && ret_valid && ret_last;
  assign line_wr    = beat_last && !miss_unc;

  assign rd_req  = (state == MISS);
  assign rd_type = 3'b100;
  assign rd_addr = {miss_tag, 4'b0000};

  always_comb begin
    fill_next                           = fill_buf;
    fill_next[{beat_cnt, 5'b00000} +: 32] = ret_data;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_miss) state_nxt = MISS;
      MISS:    if (rd_rdy)     state_nxt = REFILL;
      REFILL:  if (beat_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: line valid bits, replacement pointer, response register
  always_ff @(posedge clock) begin
    if (reset) begin
      line_vld <= '0;
      repl_ptr <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      rvalid <= 1'b0;
      if (accept_cop) begin
        case (cacop_code)
          2'd0, 2'd1: line_vld[cacop_addr[IW+3:4]] <= 1'b0;
          2'd2: begin
            for (int i = 0; i < NUM_LINES; i++) begin
              if (tag_q[i] == cacop_addr[31:4]) line_vld[i] <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (fetch_hit) begin
        rvalid <= 1'b1;
        rdata  <= data_q[hit_idx];
      end
      if (beat_last) begin
        rvalid <= 1'b1;
        rdata  <= fill_next;
      end
      if (line_wr) begin
        line_vld[repl_ptr] <= 1'b1;
        repl_ptr           <= repl_ptr + 1'b1;
      end
    end
  end

  // Data: miss address latch, fill buffer and line storage
  always_ff @(posedge clock) begin
    if (fetch_miss) begin
      miss_tag <= araddr[31:4];
      miss_unc <= uncached;
    end
    if ((state == MISS) && rd_rdy) begin
      fill_buf <= '0;
      beat_cnt <= '0;
    end
    if ((state == REFILL) && ret_valid) begin
      fill_buf <= fill_next;
      beat_cnt <= beat_cnt + 2'd1;
    end
    if (line_wr) begin
      tag_q[repl_ptr]  <= miss_tag;
      data_q[repl_ptr] <= fill_next;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (fetch_hit)  perf_hit  <= perf_hit + 32'd1;
      if (fetch_miss) perf_miss <= perf_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_line_buffer.sv
// Scoreboard bench for icache_line_buffer with a line-refill responder where mem[a] = a.
module tb_icache_line_buffer;

  logic         clock = 1'b0;
  logic         reset;
  logic         valid;
  logic         ready;
  logic [31:0]  araddr;
  logic         uncached;
  logic         rvalid;
  logic [127:0] rdata;
  logic         cacop_en;
  logic [1:0]   cacop_code;
  logic [31:0]  cacop_addr;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  perf_hit;
  logic [31:0]  perf_miss;
`endif

  icache_line_buffer #(.NUM_LINES(4)) dut (
    .clock(clock), .reset(reset), .valid(valid), .ready(ready), .araddr(araddr),
    .uncached(uncached), .rvalid(rvalid), .rdata(rdata), .cacop_en(cacop_en),
    .cacop_code(cacop_code), .cacop_addr(cacop_addr), .rd_req(rd_req), .rd_type(rd_type),
    .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
`ifdef ICACHE_PERF_CNT_EN
    .ret_data(ret_data), .perf_hit(perf_hit), .perf_miss(perf_miss)
`else
    .ret_data(ret_data)
`endif
  );

  always #5 clock = ~clock;

  int           vectors     = 0;
  int           miscompares = 0;
  int           req_cnt     = 0;
  logic [31:0]  last_req_addr = '0;
  int           resp_beats  = 4;
  bit           resp_nolast = 1'b0;
  bit           resp_busy   = 1'b0;
  logic [127:0] exp_q[$];

  function automatic logic [127:0] line_of(input logic [31:0] a, input int nb);
    logic [127:0] r;
    logic [31:0]  base;
    r    = '0;
    base = {a[31:4], 4'b0000};
    for (int w = 0; w < 4; w++)
      if (w < nb) r[32*w +: 32] = base + 32'(w * 4);
    return r;
  endfunction

  // Memory side: hold rd_rdy low one cycle, then accept and return resp_beats beats
  initial begin : responder
    logic [31:0] a;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
    forever begin
      @(negedge clock);
      if (rd_req === 1'b1 && reset === 1'b0) begin
        resp_busy = 1'b1;
        a = rd_addr;
        req_cnt++;
        last_req_addr = a;
        vectors++;
        if (rd_type !== 3'b100) begin
          miscompares++;
          $display("FAIL rd_type got %b expected 100", rd_type);
        end
        @(posedge clock); #1 rd_rdy = 1'b1;
        @(negedge clock);
        vectors++;
        if (rd_req !== 1'b1 || rd_addr !== a) begin
          miscompares++;
          $display("FAIL rd_hold got req=%b addr=%h expected req=1 addr=%h", rd_req, rd_addr, a);
        end
        @(posedge clock); #1 rd_rdy = 1'b0;
        for (int b = 0; b < resp_beats; b++) begin
          ret_valid = 1'b1;
          ret_data  = a + 32'(b * 4);
          ret_last  = !resp_nolast && (b == resp_beats - 1);
          @(posedge clock); #1;
        end
        ret_valid = 1'b0; ret_last = 1'b0; resp_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic [127:0] e;
    forever begin
      @(negedge clock);
      if (rvalid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rvalid got rdata=%h expected no response", rdata);
        end else begin
          e = exp_q.pop_front();
          if (rdata !== e) begin
            miscompares++;
            $display("FAIL rdata got %h expected %h", rdata, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic unc, input logic [127:0] exp);
    bit ok = 1'b0;
    valid = 1'b1; araddr = a; uncached = unc;
    exp_q.push_back(exp);
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clock);
      if (ready === 1'b1 && cacop_en === 1'b0) ok = 1'b1;
      @(posedge clock); #1;
    end
    valid = 1'b0; uncached = 1'b0;
    if (!ok) begin
      miscompares++;
      $display("FAIL fetch_accept got no handshake expected ready for %h", a);
    end
  endtask

  task automatic cacop(input logic [1:0] code, input logic [31:0] a);
    bit ok = 1'b0;
    cacop_en = 1'b1; cacop_code = code; cacop_addr = a;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clock);
      if (ready === 1'b1) ok = 1'b1;
      @(posedge clock); #1;
    end
    cacop_en = 1'b0;
    if (!ok) begin
      miscompares++;
      $display("FAIL cacop_accept got no handshake expected ready");
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && ready === 1'b1 && !resp_busy) ok = 1'b1;
    end
    @(posedge clock); #1;
    if (!ok) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_reqs(input string name, input int base, input int exp_n);
    vectors++;
    if (req_cnt - base !== exp_n) begin
      miscompares++;
      $display("FAIL %s refills got %0d expected %0d", name, req_cnt - base, exp_n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    vectors++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || rd_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_cycle got ready=%b rvalid=%b rd_req=%b expected 0 0 0", ready, rvalid, rd_req);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (ready !== 1'b1 || rvalid !== 1'b0 || rd_req !== 1'b0 || rdata !== 128'd0) begin
      miscompares++;
      $display("FAIL after_reset got ready=%b rvalid=%b rd_req=%b rdata=%h expected 1 0 0 0",
               ready, rvalid, rd_req, rdata);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_cold_miss();
    int base = req_cnt;
    fetch(32'h100, 1'b0, line_of(32'h100, 4));
    wait_done();
    check_reqs("cold_miss", base, 1);
    vectors++;
    if (last_req_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL cold_miss_addr got %h expected 00000100", last_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    int base = req_cnt;
    valid = 1'b1; araddr = 32'h104; uncached = 1'b0;
    exp_q.push_back(line_of(32'h100, 4));
    @(negedge clock);
    @(posedge clock); #1 araddr = 32'h108;
    exp_q.push_back(line_of(32'h100, 4));
    @(negedge clock);
    vectors++;
    if (rvalid !== 1'b1 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_first got rvalid=%b ready=%b expected 1 1", rvalid, ready);
    end
    @(posedge clock); #1 valid = 1'b0;
    @(negedge clock);
    vectors++;
    if (rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_second got rvalid=%b expected 1", rvalid);
    end
    @(posedge clock); #1;
    wait_done();
    check_reqs("hit", base, 0);
`ifdef ICACHE_PERF_CNT_EN
    vectors++;
    if (perf_hit !== 32'd2 || perf_miss !== 32'd1) begin
      miscompares++;
      $display("FAIL perf got hit=%0d miss=%0d expected 2 1", perf_hit, perf_miss);
    end
`endif
  endtask

  task automatic test_round_robin();
    int base;
    logic [31:0] seq [6];
    seq = '{32'h000, 32'h010, 32'h020, 32'h030, 32'h040, 32'h000};
    apply_reset();
    base = req_cnt;
    for (int i = 0; i < 6; i++) begin
      fetch(seq[i], 1'b0, line_of(seq[i], 4));
      wait_done();
    end
    check_reqs("rr_fill", base, 6);
    // slots now hold 040,000,020,030: 020 hits, 010 was evicted by the second 000
    fetch(32'h020, 1'b0, line_of(32'h020, 4));
    wait_done();
    check_reqs("rr_hit", base, 6);
    fetch(32'h010, 1'b0, line_of(32'h010, 4));
    wait_done();
    check_reqs("rr_evicted", base, 7);
  endtask

  task automatic test_uncached();
    int base;
    apply_reset();
    base = req_cnt;
    fetch(32'h200, 1'b1, line_of(32'h200, 4)); wait_done();
    fetch(32'h200, 1'b1, line_of(32'h200, 4)); wait_done();
    check_reqs("uncached", base, 2);
    fetch(32'h20C, 1'b0, line_of(32'h200, 4)); wait_done();
    check_reqs("uncached_then_cached", base, 3);
    fetch(32'h204, 1'b0, line_of(32'h200, 4)); wait_done();
    check_reqs("cached_hit", base, 3);
  endtask

  task automatic test_cacop();
    int base;
    apply_reset();
    base = req_cnt;
    fetch(32'h100, 1'b0, line_of(32'h100, 4)); wait_done();
    cacop(2'd2, 32'h100);
    fetch(32'h100, 1'b0, line_of(32'h100, 4)); wait_done();
    check_reqs("cacop_hit_inv", base, 2);
    cacop(2'd1, 32'h010);
    fetch(32'h100, 1'b0, line_of(32'h100, 4)); wait_done();
    check_reqs("cacop_index_inv", base, 3);
    cacop(2'd3, 32'h100);
    fetch(32'h100, 1'b0, line_of(32'h100, 4)); wait_done();
    check_reqs("cacop_nop", base, 3);
    cacop(2'd0, 32'h020);
    fetch(32'h100, 1'b0, line_of(32'h100, 4)); wait_done();
    check_reqs("cacop_index0_inv", base, 4);
  endtask

  task automatic test_cacop_with_fetch();
    int base = req_cnt;
    valid = 1'b1; araddr = 32'h108; uncached = 1'b0;
    cacop_en = 1'b1; cacop_code = 2'd3; cacop_addr = 32'h100;
    exp_q.push_back(line_of(32'h100, 4));
    @(negedge clock);
    @(posedge clock); #1 cacop_en = 1'b0;
    @(negedge clock);
    vectors++;
    if (rvalid !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cacop_priority got rvalid=%b ready=%b expected 0 1", rvalid, ready);
    end
    @(posedge clock); #1 valid = 1'b0;
    wait_done();
    check_reqs("cacop_priority", base, 0);
  endtask

  task automatic test_early_last();
    int base;
    apply_reset();
    base = req_cnt;
    resp_beats = 2;
    fetch(32'h300, 1'b0, line_of(32'h300, 2)); wait_done();
    resp_beats = 4;
    fetch(32'h30C, 1'b0, line_of(32'h300, 2)); wait_done();
    check_reqs("early_last", base, 1);
  endtask

  task automatic test_reset_mid_refill();
    int  base;
    bit  seen = 1'b0;
    apply_reset();
    resp_beats = 2; resp_nolast = 1'b1;
    valid = 1'b1; araddr = 32'h100; uncached = 1'b0;
    @(negedge clock);
    @(posedge clock); #1 valid = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clock); #1;
      if (resp_busy) seen = 1'b1;
    end
    for (int k = 0; k < 50 && resp_busy; k++) begin
      @(posedge clock); #1;
    end
    vectors++;
    if (!seen || resp_busy) begin
      miscompares++;
      $display("FAIL refill_start got seen=%b busy=%b expected 1 0", seen, resp_busy);
    end
    reset = 1'b1;
    @(negedge clock);
    @(posedge clock); #1 reset = 1'b0;
    resp_beats = 4; resp_nolast = 1'b0;
    @(negedge clock);
    vectors++;
    if (ready !== 1'b1 || rvalid !== 1'b0 || rd_req !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got ready=%b rvalid=%b rd_req=%b expected 1 0 0", ready, rvalid, rd_req);
    end
`ifdef ICACHE_PERF_CNT_EN
    vectors++;
    if (perf_hit !== 32'd0 || perf_miss !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_perf got hit=%0d miss=%0d expected 0 0", perf_hit, perf_miss);
    end
`endif
    for (int k = 0; k < 6; k++) @(negedge clock);
    @(posedge clock); #1;
    base = req_cnt;
    fetch(32'h100, 1'b0, line_of(32'h100, 4)); wait_done();
    check_reqs("after_mid_reset", base, 1);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; araddr = '0; uncached = 1'b0;
    cacop_en = 1'b0; cacop_code = '0; cacop_addr = '0;
    @(posedge clock); #1;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_round_robin();
    test_uncached();
    test_cacop();
    test_cacop_with_fetch();
    test_early_last();
    test_reset_mid_refill();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
